serial_subtractor8: RTL and testbench
=====================================

// Module: serial_subtractor8
// PURPOSE
//  Multi-cycle digit-serial subtractor, the inverse operation of the team's 8-bit
//  carry-lookahead adder datapath. Computes Di = Xi - Yi - B0, producing DIGIT bits per cycle
//  through a registered borrow chain, and emits borrow, signed-overflow and zero flags.
//  Sits behind a valid/ready request port and a valid/ready result port in the ALU datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT  2  bits resolved per cycle; NDIG = WIDTH/DIGIT cycles per operation
// PORTS
//  clk        input   1      rising-edge clock
//  rst_n      input   1      asynchronous active-low reset
//  in_valid   input   1      request valid; Xi, Yi, B0 qualified by it
//  in_ready   output  1      block can accept a request (IDLE state)
//  Xi         input   WIDTH  minuend
//  Yi         input   WIDTH  subtrahend
//  B0         input   1      borrow-in
//  out_valid  output  1      result valid (DONE state)
//  out_ready  input   1      consumer accepts result
//  Di         output  WIDTH  difference, registered
//  Bout       output  1      borrow-out; 1 iff unsigned Xi < Yi + B0
//  V          output  1      signed overflow of Xi - Yi - B0
//  Z          output  1      1 iff Di == 0
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset: state=IDLE, in_ready=1 (after release), out_valid=0, Di=0, Bout=0, V=0, Z=0,
//    digit counter=0, borrow reg=0, operand regs=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    IDLE: in_ready=1. On in_valid&in_ready: latch Xi, Yi; borrow<=B0; cnt<=0; go to RUN.
//    RUN: in_ready=0. Each cycle, for slice k=cnt: {b,d}=X[k]-Y[k]-borrow over DIGIT bits.
//         Write d to Di[k*DIGIT +: DIGIT]; borrow<=b; cnt<=cnt+1.
//         At cnt==NDIG-1, go to DONE, and Bout/V/Z are registered from the final values.
//    DONE: out_valid=1; Di, Bout, V, Z held stable. On out_ready, go to IDLE.
//  - Latency: a request accepted at edge N raises out_valid after edge N+NDIG (4 cycles at
//    defaults). Throughput: one operation per NDIG+2 cycles minimum.
//  - The DONE->IDLE handshake and a new accept never happen on the same edge. A new request
//    is accepted at the earliest on the edge after the return to IDLE.
//  - in_valid is ignored while in RUN or DONE. Operands are sampled only at accept, so
//    input changes during RUN have no effect.
//  - After the out handshake, Di/Bout/V/Z keep their last values until the next result is
//    written. Only out_valid qualifies them.
//  - V = (X[msb] != Y[msb]) && (Di[msb] != X[msb]), computed on the latched operands and the
//    final difference.
//  - Arithmetic is modulo 2^WIDTH; Bout is the final borrow of the chain.
//  - rst_n asserted mid-RUN or mid-DONE: the operation is discarded, all state returns to
//    reset values, and no out_valid is produced for it.
// TESTING
//  1. Xi=8'h5A, Yi=8'h3C, B0=0 -> Di=8'h1E, Bout=0, V=0, Z=0; out_valid 4 cycles after accept.
//  2. Xi=8'h00, Yi=8'h01, B0=0 -> Di=8'hFF, Bout=1, V=0, Z=0 (wrap-around).
//  3. Xi=8'h80, Yi=8'h01, B0=0 -> Di=8'h7F, Bout=0, V=1 (signed overflow).
//  4. Xi=8'h10, Yi=8'h0F, B0=1 -> Di=8'h00, Bout=0, V=0, Z=1 (borrow-in used).
//  5. After test 1, hold out_ready=0 for 5 cycles while pulsing in_valid with new operands
//     -> out_valid stays 1, Di stays 8'h1E, in_ready=0, nothing is accepted. Then raise
//     out_ready -> IDLE, and the next request is accepted and computed correctly.
//  6. Assert rst_n=0 two cycles into RUN -> out_valid=0 and Di=0 immediately; after release,
//     in_ready=1, and Xi=8'hFF, Yi=8'hFF, B0=0 yields Di=0, Z=1, Bout=0.

Source files
------------

// File: rtl/serial_subtractor8.sv
// serial_subtractor8: digit-serial subtractor computing Di = Xi - Yi - B0.
// It resolves DIGIT bits per cycle through a registered borrow chain and
// reports borrow-out, signed overflow and zero flags.
// Handshakes: valid/ready on the request side, valid/ready on the result side.
`timescale 1ns/1ps

module serial_subtractor8 #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Xi,
  input  logic [WIDTH-1:0] Yi,
  input  logic             B0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Di,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic               accept_s;
  logic               last_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic               borrow_r;
  logic [WIDTH-1:0]   di_r;
  logic               bout_r;
  logic               v_r;
  logic               z_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [DIGIT-1:0]   x_sl_s;
  logic [DIGIT-1:0]   y_sl_s;
  logic [DIGIT:0]     slice_s;
  logic [WIDTH-1:0]   di_nx_s;
  logic               v_nx_s;
  logic               z_nx_s;

  assign last_s = (cnt_r == CNT_LAST);

  // State register for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; DONE only returns to IDLE, so a new accept can never
  // share an edge with the result handshake.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx_s = ST_RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Current digit slice, the updated difference and the final flags.
  always_comb begin
    x_sl_s  = x_r[cnt_r*DIGIT +: DIGIT];
    y_sl_s  = y_r[cnt_r*DIGIT +: DIGIT];
    slice_s = {1'b0, x_sl_s} - {1'b0, y_sl_s} - {{DIGIT{1'b0}}, borrow_r};
    di_nx_s = di_r;
    di_nx_s[cnt_r*DIGIT +: DIGIT] = slice_s[DIGIT-1:0];
    v_nx_s  = (x_r[WIDTH-1] != y_r[WIDTH-1]) && (di_nx_s[WIDTH-1] != x_r[WIDTH-1]);
    z_nx_s  = (di_nx_s == {WIDTH{1'b0}});
  end

  // Operand capture at accept, then one borrow-chain step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
      di_r     <= {WIDTH{1'b0}};
      bout_r   <= 1'b0;
      v_r      <= 1'b0;
      z_r      <= 1'b0;
    end else if (accept_s) begin
      x_r      <= Xi;
      y_r      <= Yi;
      borrow_r <= B0;
      cnt_r    <= CNT_ZERO;
    end else if (state_r == ST_RUN) begin
      di_r     <= di_nx_s;
      borrow_r <= slice_s[DIGIT];
      cnt_r    <= cnt_r + CNT_ONE;
      if (last_s) begin
        bout_r <= slice_s[DIGIT];
        v_r    <= v_nx_s;
        z_r    <= z_nx_s;
      end else begin
        bout_r <= bout_r;
        v_r    <= v_r;
        z_r    <= z_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Handshake outputs registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Di        = di_r;
  assign Bout      = bout_r;
  assign V         = v_r;
  assign Z         = z_r;

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed self-checking bench for serial_subtractor8.
`timescale 1ns/1ps

module tb_serial_subtractor8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Xi;
  logic [7:0] Yi;
  logic       B0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Di;
  logic       Bout;
  logic       V;
  logic       Z;

  int tests_run;
  int tests_failed;

  serial_subtractor8 #(.WIDTH(8), .DIGIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Xi        (Xi),
    .Yi        (Yi),
    .B0        (B0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Di        (Di),
    .Bout      (Bout),
    .V         (V),
    .Z         (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; it must be accepted there.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic b);
    in_valid = 1'b1;
    Xi = x;
    Yi = y;
    B0 = b;
    step();
    in_valid = 1'b0;
    chk("accept_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  // Wait (bounded) for the result, check latency and values.
  task automatic await_result(input string tag, input logic [7:0] d, input logic bo,
                              input logic v, input logic z);
    int lat;
    lat = 1;
    step();
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd4);
    chk({tag, "_di"},   {24'd0, Di},   {24'd0, d});
    chk({tag, "_bout"}, {31'd0, Bout}, {31'd0, bo});
    chk({tag, "_v"},    {31'd0, V},    {31'd0, v});
    chk({tag, "_z"},    {31'd0, Z},    {31'd0, z});
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
  endtask

  // Complete the result handshake and confirm the return to IDLE.
  task automatic take_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Xi = 8'h00;
    Yi = 8'h00;
    B0 = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_di",        {24'd0, Di},        32'd0);
    chk("rst_bout",      {31'd0, Bout},      32'd0);
    chk("rst_v",         {31'd0, V},         32'd0);
    chk("rst_z",         {31'd0, Z},         32'd0);

    // Basic vectors
    send(8'h5A, 8'h3C, 1'b0);
    await_result("t1", 8'h1E, 1'b0, 1'b0, 1'b0);
    take_result("t1");

    send(8'h00, 8'h01, 1'b0);
    await_result("t2", 8'hFF, 1'b1, 1'b0, 1'b0);
    take_result("t2");

    send(8'h80, 8'h01, 1'b0);
    await_result("t3", 8'h7F, 1'b0, 1'b1, 1'b0);
    take_result("t3");

    send(8'h10, 8'h0F, 1'b1);
    await_result("t4", 8'h00, 1'b0, 1'b0, 1'b1);
    take_result("t4");

    // Backpressure: result held, requests ignored while DONE
    send(8'h5A, 8'h3C, 1'b0);
    await_result("t5a", 8'h1E, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      Xi = 8'h01 + 8'(i);
      Yi = 8'h02;
      step();
      chk("t5_hold_ov", {31'd0, out_valid}, 32'd1);
      chk("t5_hold_di", {24'd0, Di},        32'h1E);
      chk("t5_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    // Request already pending on the return edge must wait one more edge
    in_valid  = 1'b1;
    Xi = 8'h33;
    Yi = 8'h11;
    B0 = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_ret_ov",  {31'd0, out_valid}, 32'd0);
    chk("t5_ret_rdy", {31'd0, in_ready},  32'd1);
    chk("t5_ret_di",  {24'd0, Di},        32'h1E);
    send(8'h33, 8'h11, 1'b0);
    await_result("t5b", 8'h22, 1'b0, 1'b0, 1'b0);
    take_result("t5b");

    // Reset in the middle of RUN
    send(8'h5A, 8'h3C, 1'b0);
    step();
    Xi = 8'hAA;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_di", {24'd0, Di},        32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_rel_rdy", {31'd0, in_ready},  32'd1);
    chk("t6_rel_ov",  {31'd0, out_valid}, 32'd0);
    repeat (4) step();
    chk("t6_no_stale_ov", {31'd0, out_valid}, 32'd0);
    send(8'hFF, 8'hFF, 1'b0);
    await_result("t6", 8'h00, 1'b0, 1'b0, 1'b1);
    take_result("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
